// File: rtl/ex_ctrl_pkg.sv
// Shared pipeline-control definitions: EX-stage control FSM state encoding
// and the default wrong-path squash depth.
package PipelineReg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } ex_state_t;

  // Wrong-path cycles squashed after an accepted redirect (legal 1..7).
  localparam int unsigned FLUSH_DEPTH_DEF = 2;

endpackage

// File: rtl/ex_ctrl_hazard_detect.sv
// Load-use hazard detection: a load in EX whose non-zero destination is read
// by the instruction currently in ID.
module hazard_detect (
  input  logic       ex_valid,
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  output logic       hazard
);

  // Purely combinational compare of EX destination against ID sources.
  always_comb begin
    hazard = ex_valid && ex_is_load && (ex_rd != 5'd0) &&
             ((id_use_rs1 && (id_rs1 == ex_rd)) ||
              (id_use_rs2 && (id_rs2 == ex_rd)));
  end

endmodule

// File: rtl/ex_ctrl.sv
// EX-stage control: fetch redirect on taken branches/jumps, IF/ID squash of
// wrong-path instructions, load-use interlock and target-misalignment trap.
// Build option: define EX_CTRL_RVC_EN to accept 16-bit aligned targets.
module ex_ctrl
  import PipelineReg::*;
#(
  parameter int unsigned FLUSH_DEPTH = FLUSH_DEPTH_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ex_valid,
  input  logic [31:0] i_ex_pc,
  input  logic        i_is_branch,
  input  logic        i_is_jal,
  input  logic        i_is_jalr,
  input  logic        i_branch_taken,
  input  logic [31:0] i_target,
  input  logic        i_ex_is_load,
  input  logic [4:0]  i_ex_rd,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic        i_id_use_rs1,
  input  logic        i_id_use_rs2,
  input  logic        i_if_ready,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_flush_if,
  output logic        o_flush_id,
  output logic        o_stall_if,
  output logic        o_stall_id,
  output logic        o_bubble_ex,
  output logic        o_misalign,
  output logic [31:0] o_misalign_pc,
  output logic        o_busy
);

  ex_state_t  state;
  logic [2:0] flush_cnt;
  logic       stall_flag;
  logic       load_use;
  logic       xfer;
  logic       target_ok;
  logic [31:0] target_pc;

  hazard_detect u_hazard (
    .ex_valid   (i_ex_valid),
    .ex_is_load (i_ex_is_load),
    .ex_rd      (i_ex_rd),
    .id_rs1     (i_id_rs1),
    .id_rs2     (i_id_rs2),
    .id_use_rs1 (i_id_use_rs1),
    .id_use_rs2 (i_id_use_rs2),
    .hazard     (load_use)
  );

  // Classify the EX instruction: does it transfer control, and where to.
  always_comb begin
    xfer = i_ex_valid && (i_is_jal || i_is_jalr || (i_is_branch && i_branch_taken));
`ifdef EX_CTRL_RVC_EN
    target_ok = 1'b1;
    target_pc = i_target & ~32'h1;
`else
    target_ok = !i_target[1];
    target_pc = i_target;
`endif
  end

  // Control FSM; every output is a register updated here.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state         <= RUN;
      flush_cnt     <= '0;
      stall_flag    <= 1'b0;
      o_redirect    <= 1'b0;
      o_redirect_pc <= '0;
      o_flush_if    <= 1'b0;
      o_flush_id    <= 1'b0;
      o_stall_if    <= 1'b0;
      o_stall_id    <= 1'b0;
      o_bubble_ex   <= 1'b0;
      o_misalign    <= 1'b0;
      o_misalign_pc <= '0;
      o_busy        <= 1'b0;
    end else begin
      // Single-cycle pulses default low every cycle.
      o_stall_if    <= 1'b0;
      o_stall_id    <= 1'b0;
      o_bubble_ex   <= 1'b0;
      o_misalign    <= 1'b0;
      o_misalign_pc <= '0;
      case (state)
        RUN: begin
          if (xfer && target_ok) begin
            state         <= REDIRECT;
            o_redirect    <= 1'b1;
            o_redirect_pc <= target_pc;
            o_flush_if    <= 1'b1;
            o_flush_id    <= 1'b1;
            o_busy        <= 1'b1;
            stall_flag    <= 1'b0;
          end else if (xfer) begin
            // Misaligned target: trap instead of redirecting, still squash.
            state         <= FLUSH;
            flush_cnt     <= 3'(FLUSH_DEPTH);
            o_misalign    <= 1'b1;
            o_misalign_pc <= i_ex_pc;
            o_flush_if    <= 1'b1;
            o_flush_id    <= 1'b1;
            o_busy        <= 1'b1;
            stall_flag    <= 1'b0;
          end else begin
            // Flag tracks that the current load already stalled once.
            o_stall_if  <= load_use && !stall_flag;
            o_stall_id  <= load_use && !stall_flag;
            o_bubble_ex <= load_use && !stall_flag;
            stall_flag  <= load_use;
          end
        end
        REDIRECT: begin
          if (i_if_ready) begin
            state         <= FLUSH;
            flush_cnt     <= 3'(FLUSH_DEPTH);
            o_redirect    <= 1'b0;
            o_redirect_pc <= '0;
          end
        end
        FLUSH: begin
          if (flush_cnt > 3'd1) begin
            flush_cnt <= flush_cnt - 3'd1;
          end else begin
            state      <= RUN;
            flush_cnt  <= '0;
            o_flush_if <= 1'b0;
            o_flush_id <= 1'b0;
            o_busy     <= 1'b0;
          end
        end
        default: begin
          state         <= RUN;
          flush_cnt     <= '0;
          stall_flag    <= 1'b0;
          o_redirect    <= 1'b0;
          o_redirect_pc <= '0;
          o_flush_if    <= 1'b0;
          o_flush_id    <= 1'b0;
          o_busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_ctrl.sv
// Self-checking bench for ex_ctrl: directed scenarios plus randomized
// transfers and load-use trials, with expectations derived from cycle counts.
module tb_ex_ctrl;

  localparam int D = 2;
`ifdef EX_CTRL_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_ex_valid;
  logic [31:0] i_ex_pc;
  logic        i_is_branch, i_is_jal, i_is_jalr, i_branch_taken;
  logic [31:0] i_target;
  logic        i_ex_is_load;
  logic [4:0]  i_ex_rd, i_id_rs1, i_id_rs2;
  logic        i_id_use_rs1, i_id_use_rs2;
  logic        i_if_ready;
  logic        o_redirect;
  logic [31:0] o_redirect_pc;
  logic        o_flush_if, o_flush_id;
  logic        o_stall_if, o_stall_id, o_bubble_ex;
  logic        o_misalign;
  logic [31:0] o_misalign_pc;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  ex_ctrl #(.FLUSH_DEPTH(D)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_ex_valid(i_ex_valid), .i_ex_pc(i_ex_pc),
    .i_is_branch(i_is_branch), .i_is_jal(i_is_jal), .i_is_jalr(i_is_jalr),
    .i_branch_taken(i_branch_taken), .i_target(i_target),
    .i_ex_is_load(i_ex_is_load), .i_ex_rd(i_ex_rd),
    .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
    .i_id_use_rs1(i_id_use_rs1), .i_id_use_rs2(i_id_use_rs2),
    .i_if_ready(i_if_ready),
    .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
    .o_flush_if(o_flush_if), .o_flush_id(o_flush_id),
    .o_stall_if(o_stall_if), .o_stall_id(o_stall_id), .o_bubble_ex(o_bubble_ex),
    .o_misalign(o_misalign), .o_misalign_pc(o_misalign_pc),
    .o_busy(o_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic redir, input logic [31:0] rpc,
                         input logic flush, input logic stall, input logic mis,
                         input logic [31:0] mpc, input logic busy);
    chk({tag, ".redirect"},    32'(o_redirect),    32'(redir));
    chk({tag, ".redirect_pc"}, o_redirect_pc,      rpc);
    chk({tag, ".flush_if"},    32'(o_flush_if),    32'(flush));
    chk({tag, ".flush_id"},    32'(o_flush_id),    32'(flush));
    chk({tag, ".stall_if"},    32'(o_stall_if),    32'(stall));
    chk({tag, ".stall_id"},    32'(o_stall_id),    32'(stall));
    chk({tag, ".bubble_ex"},   32'(o_bubble_ex),   32'(stall));
    chk({tag, ".misalign"},    32'(o_misalign),    32'(mis));
    chk({tag, ".misalign_pc"}, o_misalign_pc,      mpc);
    chk({tag, ".busy"},        32'(o_busy),        32'(busy));
  endtask

  task automatic idle();
    i_ex_valid = 0; i_ex_pc = '0; i_is_branch = 0; i_is_jal = 0; i_is_jalr = 0;
    i_branch_taken = 0; i_target = '0; i_ex_is_load = 0; i_ex_rd = '0;
    i_id_rs1 = '0; i_id_rs2 = '0; i_id_use_rs1 = 0; i_id_use_rs2 = 0;
    i_if_ready = 1;
  endtask

  // Wrong-path noise: anything at all may sit in EX while squashing.
  task automatic garbage();
    int unsigned cls;
    cls = $urandom_range(3);
    i_ex_valid = 1'($urandom); i_ex_pc = $urandom; i_target = $urandom;
    i_is_branch = (cls == 0); i_is_jal = (cls == 1); i_is_jalr = (cls == 2);
    i_branch_taken = 1'($urandom); i_ex_is_load = 1'($urandom);
    i_ex_rd = 5'($urandom_range(3)); i_id_rs1 = 5'($urandom_range(3));
    i_id_rs2 = 5'($urandom_range(3));
    i_id_use_rs1 = 1'($urandom); i_id_use_rs2 = 1'($urandom);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // kind: 0 = taken BEQ, 1 = JAL, 2 = JALR. wait_n = cycles fetch refuses.
  task automatic transfer(input string tag, input int kind, input logic [31:0] pc,
                          input logic [31:0] target, input int wait_n, input bit with_hazard);
    bit legal;
    logic [31:0] exp_pc;
    int total;
    idle();
    i_ex_valid = 1; i_ex_pc = pc; i_target = target;
    i_is_branch = (kind == 0); i_is_jal = (kind == 1); i_is_jalr = (kind == 2);
    i_branch_taken = 1;
    if (with_hazard) begin
      i_ex_is_load = 1; i_ex_rd = 5'd5; i_id_rs2 = 5'd5; i_id_use_rs2 = 1;
    end
    legal  = RVC || !target[1];
    exp_pc = RVC ? (target & ~32'h1) : target;
    total  = legal ? (wait_n + 1 + D) : D;
    step();
    for (int k = 1; k <= total + 1; k++) begin
      if (legal) begin
        bit r = (k <= wait_n + 1);
        chk_all($sformatf("%s.k%0d", tag, k), r, r ? exp_pc : 32'h0,
                k <= total, 1'b0, 1'b0, 32'h0, k <= total);
      end else begin
        chk_all($sformatf("%s.k%0d", tag, k), 1'b0, 32'h0,
                k <= total, 1'b0, k == 1, (k == 1) ? pc : 32'h0, k <= total);
      end
      if (k <= total) begin
        garbage();
        if (legal && k <= wait_n + 1) i_if_ready = (k > wait_n);
        else i_if_ready = 1'($urandom);
        step();
      end
    end
    idle();
  endtask

  initial begin
    logic exp_h;
    idle();
    i_reset = 0;
    step(); step();
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    i_reset = 1;
    step();
    chk_all("idle", 0, 0, 0, 0, 0, 0, 0);

    // Taken BEQ accepted immediately; JAL held off by fetch for 3 cycles.
    transfer("beq100", 0, 32'h0000_0010, 32'h0000_0100, 0, 0);
    transfer("jal200", 1, 32'h0000_0020, 32'h0000_0200, 3, 0);
    // JALR to a halfword-aligned target.
    transfer("jalr102", 2, 32'h0000_0040, 32'h0000_0102, 0, 0);
    // Redirect and load-use together: redirect only.
    transfer("br_lu", 0, 32'h0000_0050, 32'h0000_0300, 1, 1);

    // Not-taken branch: no activity.
    idle(); i_ex_valid = 1; i_is_branch = 1; i_branch_taken = 0; i_target = 32'h400;
    step();
    chk_all("nottaken", 0, 0, 0, 0, 0, 0, 0);

    // LW x5 in EX, ID reads x5 via rs2: one stall cycle even if held.
    idle(); i_ex_valid = 1; i_ex_is_load = 1; i_ex_rd = 5'd5; i_id_rs2 = 5'd5; i_id_use_rs2 = 1;
    step();
    chk_all("lu_x5", 0, 0, 0, 1, 0, 0, 0);
    step();
    chk_all("lu_x5_hold", 0, 0, 0, 0, 0, 0, 0);
    idle(); step();
    // Load to x0 never interlocks.
    i_ex_valid = 1; i_ex_is_load = 1; i_ex_rd = 5'd0; i_id_rs1 = 5'd0; i_id_use_rs1 = 1;
    step();
    chk_all("lu_x0", 0, 0, 0, 0, 0, 0, 0);
    idle(); step();

    // Randomized load-use trials.
    for (int t = 0; t < 40; t++) begin
      idle();
      i_ex_valid = ($urandom_range(3) != 0); i_ex_is_load = 1'($urandom);
      i_ex_rd = 5'($urandom_range(3)); i_id_rs1 = 5'($urandom_range(3));
      i_id_rs2 = 5'($urandom_range(3));
      i_id_use_rs1 = 1'($urandom); i_id_use_rs2 = 1'($urandom);
      exp_h = i_ex_valid && i_ex_is_load && (i_ex_rd != 0) &&
              ((i_id_use_rs1 && i_id_rs1 == i_ex_rd) || (i_id_use_rs2 && i_id_rs2 == i_ex_rd));
      step();
      chk_all($sformatf("rlu%0d", t), 0, 0, 0, exp_h, 0, 0, 0);
      step();
      chk_all($sformatf("rlu%0d_hold", t), 0, 0, 0, 0, 0, 0, 0);
      idle(); step();
    end

    // Randomized control transfers.
    for (int t = 0; t < 10; t++) begin
      logic [31:0] tg;
      tg = $urandom & ~32'h1;
      if ($urandom_range(2) == 0) tg[1] = 1'b1;
      transfer($sformatf("rx%0d", t), int'($urandom_range(2)), $urandom & ~32'h3, tg,
               int'($urandom_range(3)), 1'($urandom));
    end

    // Reset asserted during FLUSH abandons everything at once.
    idle(); i_ex_valid = 1; i_is_jal = 1; i_target = 32'h0000_0500;
    step();
    idle(); step();
    chk("pre_reset.busy", 32'(o_busy), 32'h1);
    #2 i_reset = 0;
    #1 chk_all("async_reset", 0, 0, 0, 0, 0, 0, 0);
    step();
    i_reset = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_all($sformatf("post_reset%0d", k), 0, 0, 0, 0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
